// File: rtl/seg7_reader.sv
// Receive side of the 7-segment display link: synchronizes the segment bus,
// debounces it, decodes the hex digit and streams each new symbol out.
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [3:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err_pulse,
    output logic [7:0] err_count,
    output logic       overrun
);

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    typedef enum logic {
        EMPTY_S = 1'b0,
        FULL_S  = 1'b1
    } state_t;

    // Decode result packing: {legal, blank, value}.
    function automatic logic [5:0] seg_decode(input logic [6:0] seg);
        logic [5:0] res;
        res = 6'b00_0000;
        case (seg)
            7'h3F:   res = {1'b1, 1'b0, 4'h0};
            7'h06:   res = {1'b1, 1'b0, 4'h1};
            7'h5B:   res = {1'b1, 1'b0, 4'h2};
            7'h4F:   res = {1'b1, 1'b0, 4'h3};
            7'h66:   res = {1'b1, 1'b0, 4'h4};
            7'h6D:   res = {1'b1, 1'b0, 4'h5};
            7'h7D:   res = {1'b1, 1'b0, 4'h6};
            7'h07:   res = {1'b1, 1'b0, 4'h7};
            7'h7F:   res = {1'b1, 1'b0, 4'h8};
            7'h6F:   res = {1'b1, 1'b0, 4'h9};
            7'h77:   res = {1'b1, 1'b0, 4'hA};
            7'h7C:   res = {1'b1, 1'b0, 4'hB};
            7'h39:   res = {1'b1, 1'b0, 4'hC};
            7'h5E:   res = {1'b1, 1'b0, 4'hD};
            7'h79:   res = {1'b1, 1'b0, 4'hE};
            7'h71:   res = {1'b1, 1'b0, 4'hF};
            7'h00:   res = {1'b0, 1'b1, 4'h0};
            default: res = {1'b0, 1'b0, 4'h0};
        endcase
        return res;
    endfunction

    logic [6:0] s1_r;
    logic [6:0] s2_r;
    logic [6:0] s2_prev_r;
    logic [7:0] cnt_r;
    logic [6:0] last_r;
    state_t     state_r;
    logic [3:0] out_data_r;
    logic       out_valid_r;
    logic       err_pulse_r;
    logic [7:0] err_count_r;
    logic       overrun_r;

    logic [7:0] cnt_next_s;
    logic       accept_s;
    logic [5:0] dec_s;
    logic       legal_s;
    logic       illegal_s;
    logic       handshake_s;

    // Stability counter next value and accept/decode qualification.
    always_comb begin
        cnt_next_s = cnt_r;
        if (s2_r != s2_prev_r) begin
            cnt_next_s = 8'd0;
        end else if (cnt_r < STABLE_C) begin
            cnt_next_s = cnt_r + 8'd1;
        end else begin
            cnt_next_s = cnt_r;
        end
        // Accept only on the transition into the threshold, so a held pattern fires once.
        accept_s    = (cnt_next_s == STABLE_C) && (cnt_r != STABLE_C) && (s2_r != last_r);
        dec_s       = seg_decode(s2_r);
        legal_s     = accept_s && dec_s[5];
        illegal_s   = accept_s && !dec_s[5] && !dec_s[4];
        handshake_s = out_valid_r && out_ready;
    end

    // Input synchronizer, debounce counter and last accepted pattern.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_r      <= 7'h00;
            s2_r      <= 7'h00;
            s2_prev_r <= 7'h00;
            cnt_r     <= 8'd0;
            last_r    <= 7'h00;
        end else begin
            s1_r      <= seg_in;
            s2_r      <= s1_r;
            s2_prev_r <= s2_r;
            cnt_r     <= cnt_next_s;
            if (accept_s) begin
                last_r <= s2_r;
            end
        end
    end

    // Output stream state machine with error and overrun reporting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= EMPTY_S;
            out_data_r  <= 4'h0;
            out_valid_r <= 1'b0;
            err_pulse_r <= 1'b0;
            err_count_r <= 8'd0;
            overrun_r   <= 1'b0;
        end else begin
            err_pulse_r <= illegal_s;
            if (illegal_s && (err_count_r != 8'hFF)) begin
                err_count_r <= err_count_r + 8'd1;
            end
            case (state_r)
                EMPTY_S: begin
                    if (legal_s) begin
                        out_data_r  <= dec_s[3:0];
                        out_valid_r <= 1'b1;
                        state_r     <= FULL_S;
                    end
                end
                FULL_S: begin
                    if (legal_s) begin
                        // A consumer draining this very cycle frees the slot for the new digit.
                        if (handshake_s) begin
                            out_data_r <= dec_s[3:0];
                        end else begin
                            overrun_r <= 1'b1;
                        end
                    end else if (handshake_s) begin
                        out_valid_r <= 1'b0;
                        state_r     <= EMPTY_S;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= EMPTY_S;
                end
            endcase
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign err_pulse = err_pulse_r;
    assign err_count = err_count_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed self-checking bench for seg7_reader with default STABLE_CYCLES=4.
module tb_seg7_reader;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_in;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       err_pulse;
    logic [7:0] err_count;
    logic       overrun;

    int n_checks;
    int n_errors;
    int n_err_pulse;
    logic [3:0] got[$];

    logic [6:0] legal_pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_reader #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record delivered symbols and error pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got.push_back(out_data);
        if (rst_n && err_pulse) n_err_pulse++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg_in = p;
        repeat (n) step();
    endtask

    task automatic do_reset();
        seg_in = 7'h00;
        rst_n  = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (8) step();
    endtask

    task automatic clear_mon();
        got.delete();
        n_err_pulse = 0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        seg_in    = 7'h00;
        out_ready = 1'b0;
        clear_mon();

        // Reset state
        do_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_errp", err_pulse, 0);
        chk("rst_errc", err_count, 0);
        chk("rst_ovr", overrun, 0);

        // Latency of a single digit: visible after edge 6, drained at edge 7
        out_ready = 1'b1;
        clear_mon();
        seg_in = 7'h5B;
        repeat (6) step();
        chk("lat_e5_valid", out_valid, 0);
        step();
        chk("lat_e6_valid", out_valid, 1);
        chk("lat_e6_data", out_data, 2);
        step();
        chk("lat_e7_valid", out_valid, 0);
        hold(7'h5B, 20);
        chk("hold_once_n", got.size(), 1);
        if (got.size() > 0) chk("hold_once_v", got[0], 2);

        // Sweep of all legal digits
        clear_mon();
        for (int i = 0; i < 16; i++) hold(legal_pat[i], 10);
        chk("sweep_n", got.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < got.size()) chk($sformatf("sweep_%0d", i), got[i], i);
        end
        chk("sweep_errc", err_count, 0);
        chk("sweep_ovr", overrun, 0);

        // Repeat via blank, then repeat without blank
        clear_mon();
        hold(7'h4F, 10);
        hold(7'h00, 10);
        hold(7'h4F, 10);
        hold(7'h4F, 10);
        chk("blank_rep_n", got.size(), 2);
        if (got.size() > 1) chk("blank_rep_v", got[1], 3);

        // Illegal patterns
        clear_mon();
        hold(7'h01, 10);
        hold(7'h7E, 10);
        chk("illegal_pulses", n_err_pulse, 2);
        chk("illegal_errc", err_count, 2);
        chk("illegal_nosym", got.size(), 0);
        for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 7'h01 : 7'h7E, 6);
        chk("errc_sat", err_count, 255);
        chk("errc_ovr", overrun, 0);

        // Overrun with stalled consumer
        do_reset();
        clear_mon();
        out_ready = 1'b0;
        hold(7'h06, 10);
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, 1);
        hold(7'h66, 10);
        chk("ovr_data", out_data, 1);
        chk("ovr_flag", overrun, 1);
        out_ready = 1'b1;
        step();
        chk("drain_valid", out_valid, 0);
        chk("drain_n", got.size(), 1);
        if (got.size() > 0) chk("drain_v", got[0], 1);

        // Handshake on the exact accept cycle of the next digit
        do_reset();
        clear_mon();
        out_ready = 1'b0;
        hold(7'h06, 10);
        seg_in = 7'h66;
        repeat (6) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("same_valid", out_valid, 1);
        chk("same_data", out_data, 4);
        chk("same_ovr", overrun, 0);
        chk("same_n", got.size(), 1);
        out_ready = 1'b1;
        step();
        step();
        chk("same_drain_n", got.size(), 2);
        if (got.size() > 1) chk("same_drain_v", got[1], 4);

        // Glitch shorter than the stability window
        do_reset();
        clear_mon();
        out_ready = 1'b1;
        hold(7'h3F, 10);
        hold(7'h07, 3);
        hold(7'h3F, 10);
        chk("glitch_n", got.size(), 1);
        chk("glitch_errc", err_count, 0);
        chk("glitch_pulses", n_err_pulse, 0);

        // Reset while a symbol is pending
        out_ready = 1'b0;
        hold(7'h01, 10);
        hold(7'h77, 10);
        hold(7'h7C, 10);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_ovr", overrun, 1);
        chk("pre_rst_errc", err_count, 1);
        seg_in = 7'h00;
        rst_n  = 1'b0;
        step();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_errc", err_count, 0);
        chk("mid_rst_ovr", overrun, 0);
        chk("mid_rst_errp", err_pulse, 0);
        rst_n = 1'b1;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
Name: seg7_reader

Overview:
- Receive side of the 7-segment display interface: watches a 7-bit segment bus (from an on-chip driver or an external display pad) and recovers the hex nibble it shows.
- Synchronizes the bus, requires each pattern to be stable for a programmable time, inverts the hex-to-segment map, and delivers each new digit over a valid/ready stream.
- Flags illegal patterns and overruns.
- Used for loopback self-test of the display path and for reading digits back from a neighbouring design.

Parameters:
- STABLE_CYCLES, 4, number of consecutive cycles a synchronized pattern must hold before it is accepted; legal range 1..255.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- seg_in  input  7  segment bus, bit0=top(a), bit1=upper-right(b), bit2=lower-right(c), bit3=bottom(d), bit4=lower-left(e), bit5=upper-left(f), bit6=middle(g); 1=lit; asynchronous to clk.
- out_data  output  4  decoded hex value.
- out_valid  output  1  out_data holds an undelivered symbol.
- out_ready  input  1  consumer accepts on a cycle where out_valid && out_ready.
- err_pulse  output  1  one-cycle pulse when a stable illegal pattern is accepted.
- err_count  output  8  count of illegal patterns, saturating at 255.
- overrun  output  1  sticky; set when a valid symbol is dropped because out_valid was still pending.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - out_data=0, out_valid=0, err_pulse=0, err_count=0, overrun=0.
  - Sync flops, stability counter and last_accepted all cleared; last_accepted=7'h00.
  - Reset mid-operation discards any pending symbol.
- Synchronizer: 2-flop chain on seg_in; all logic uses the second-stage value, s2.
- Stability counter, 8 bits:
  - Cleared to 0 on any cycle where s2 differs from its previous-cycle value.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Accept event: the counter reaches STABLE_CYCLES on this cycle (transitions to it) and s2 != last_accepted.
  - On accept, last_accepted <= s2.
- Latency: a pattern first sampled at edge 0 and held produces its accept effect (out_valid high, or err_pulse) visible after edge STABLE_CYCLES+2. With the default, that is edge 6.
- Decode on accept. Legal map, hex pattern -> value:
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7.
  - 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F.
- Blank pattern (00):
  - Updates last_accepted only.
  - No output, no error.
  - This lets a repeated digit separated by blank be delivered twice.
- Any other pattern:
  - err_pulse=1 for exactly one cycle.
  - err_count increments unless already 255.
  - No symbol is produced.
- Legal symbol, output state machine:
  - EMPTY (out_valid=0): load out_data, go to FULL.
  - FULL (out_valid=1): out_data and out_valid are held stable until out_valid && out_ready, then return to EMPTY.
- Simultaneous events in FULL:
  - Handshake completes in the same cycle as a new accept: load the new symbol and stay FULL. No overrun.
  - New legal accept while FULL with no handshake: symbol dropped, overrun <= 1 (sticky until reset), out_data unchanged.
  - Illegal or blank accepts never set overrun.
- The same stable pattern held indefinitely is accepted once only. It re-accepts only after a different pattern has itself been accepted.
- Glitches shorter than STABLE_CYCLES cycles never produce an accept, and never change last_accepted.
- out_ready is ignored while out_valid=0.

Test Plan:
- Reset, then hold seg_in=7'h5B with out_ready=1 -> out_valid high for one cycle after edge 6 with out_data=2. Further holding produces nothing.
- Sweep all 16 legal patterns, each held 10 cycles, out_ready=1 -> symbols 0..F delivered in order; err_count=0; overrun=0.
- Apply 7'h4F, then 7'h00 for 10 cycles, then 7'h4F again -> value 3 delivered twice. Apply 4F→4F with no blank between -> delivered once.
- Hold 7'h01, then 7'h7E, each 10 cycles -> two err_pulse single-cycle pulses, err_count=2, out_valid stays 0. Apply 300 alternating illegal patterns -> err_count saturates at 255.
- Set out_ready=0, apply 7'h06 then 7'h66 -> out_data stays 1 with out_valid=1, overrun=1. Then raise out_ready -> one transfer of value 1, then out_valid=0. Repeat with out_ready pulsed on the exact accept cycle of the second symbol -> value 4 loaded, overrun stays 0.
- Glitch seg_in to 7'h07 for 3 cycles (STABLE_CYCLES=4) between stable 3F holds -> no output, no error. Assert rst_n=0 while out_valid=1 -> all outputs return to 0 the next cycle.
